// File: rtl/mod_inv_binary_pkg.sv
// Shared ECC definitions: default operand width, the secp256k1 field prime,
// and the control state encoding reused by the affine-conversion FSM.
package mod_inv_binary_pkg;

  localparam int unsigned ECC_WIDTH = 256;

  // secp256k1 field prime: 2^256 - 2^32 - 977
  localparam logic [255:0] P256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_FINISH = 2'd2
  } ecc_state_e;

  // Iteration cap used by the inverter for a given operand width
  function automatic int unsigned inv_max_steps(input int unsigned w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/mod_inv_binary_sub.sv
// Combinational modular subtraction res_c = (x - y) mod p.
// Ports:
//   x, y  : minuend / subtrahend, both in [0,p)
//   p     : modulus
//   res_c : result in [0,p)
module mod_sub_p
  import mod_inv_binary_pkg::*;
#(
  parameter int unsigned WIDTH = ECC_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] res_c
);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] fix;

  // Extra top bit of the difference is the borrow
  assign diff  = {1'b0, x} - {1'b0, y};
  // On borrow x-y+p lies in [0,p), so the modulo-2^WIDTH sum is exact
  assign fix   = diff[WIDTH-1:0] + p;
  assign res_c = diff[WIDTH] ? fix : diff[WIDTH-1:0];

endmodule

// File: rtl/mod_inv_binary.sv
// Sequential modular inverter: inv = a^-1 mod p via the binary extended
// Euclidean algorithm, one reduction step per clock.
// Ports:
//   clk, nrst : clock (rising edge), async active-low reset
//   start     : request pulse, accepted only in IDLE
//   a, p      : operand and odd modulus, sampled at the accepted start edge
//   inv       : result, held until the next completion
//   done      : one-cycle completion pulse
//   err       : valid with done; invalid operands or step cap reached
//   busy      : high while a request is in flight (ITER and FINISH)
module mod_inv_binary
  import mod_inv_binary_pkg::*;
#(
  parameter int unsigned WIDTH     = ECC_WIDTH,
  parameter int unsigned MAX_STEPS = 2 * WIDTH + 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] inv,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

  ecc_state_e       state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] x1_sub_c;
  logic [WIDTH-1:0] x2_sub_c;
  logic             operands_ok_c;

  // x/2 mod m for odd m: add m first when x is odd, at WIDTH+1 bits
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return sum[WIDTH:1];
  endfunction

  // Coefficient updates for the two subtraction branches
  mod_sub_p #(.WIDTH(WIDTH)) u_sub_x1 (
    .x     (x1_q),
    .y     (x2_q),
    .p     (p_q),
    .res_c (x1_sub_c)
  );

  mod_sub_p #(.WIDTH(WIDTH)) u_sub_x2 (
    .x     (x2_q),
    .y     (x1_q),
    .p     (p_q),
    .res_c (x2_sub_c)
  );

  // Operand guard: 0 < a < p, p odd and greater than one
  assign operands_ok_c = (a != '0) && (a < p) && p[0] && (p > WIDTH'(1));

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      p_q     <= '0;
      step_q  <= '0;
      inv_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      p_q     <= p_d;
      step_q  <= step_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    p_d     = p_q;
    step_d  = step_q;
    inv_d   = inv_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (operands_ok_c) begin
            p_d     = p;
            u_d     = a;
            v_d     = p;
            x1_d    = WIDTH'(1);
            x2_d    = '0;
            step_d  = '0;
            state_d = ST_ITER;
          end else begin
            inv_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end

      ST_ITER: begin
        if (u_q == WIDTH'(1)) begin
          inv_d   = x1_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (v_q == WIDTH'(1)) begin
          inv_d   = x2_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (step_q == STEP_W'(MAX_STEPS)) begin
          // Reached only when gcd(a,p) != 1 or the cap is too tight
          inv_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          step_d = step_q + STEP_W'(1);
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = half_mod(x1_q, p_q);
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = half_mod(x2_q, p_q);
          end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = x1_sub_c;
          end else begin
            v_d  = v_q - u_q;
            x2_d = x2_sub_c;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign inv  = inv_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mod_inv_binary.sv
// Self-checking bench for mod_inv_binary: directed corner cases plus random
// small-modulus requests checked against an extended-Euclid reference model.
module tb_mod_inv_binary;
  import mod_inv_binary_pkg::*;

  localparam int unsigned W    = 256;
  localparam int unsigned MAXS = 2 * W + 2;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] p;
  logic [W-1:0] inv;
  logic         done;
  logic         err;
  logic         busy;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  mod_inv_binary #(.WIDTH(W), .MAX_STEPS(MAXS)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .a     (a),
    .p     (p),
    .inv   (inv),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient-based extended Euclid, coefficients kept mod p
  function automatic void ref_inv(input logic [W-1:0] ai, input logic [W-1:0] pi,
                                  output logic [W-1:0] ri, output logic re);
    logic [W-1:0]   r0, r1, s0, s1, q, t, rn, sn;
    logic [2*W-1:0] prod;
    ri = '0;
    re = 1'b1;
    if (ai == '0 || ai >= pi || !pi[0] || pi <= W'(1)) return;
    r0 = ai; r1 = pi; s0 = W'(1); s1 = '0;
    while (r1 != '0) begin
      q    = r0 / r1;
      rn   = r0 - q * r1;
      prod = (2*W)'(q) * (2*W)'(s1);
      t    = W'(prod % (2*W)'(pi));
      sn   = (s0 >= t) ? s0 - t : s0 + (pi - t);
      r0 = r1; r1 = rn; s0 = s1; s1 = sn;
    end
    if (r0 == W'(1)) begin
      ri = s0;
      re = 1'b0;
    end
  endfunction

  // One request; operands scrambled after the start edge. lat counts E0 as 1.
  task automatic do_req(input string tag, input logic [W-1:0] ai, input logic [W-1:0] pi,
                        output logic [W-1:0] got_inv, output logic got_err, output int lat);
    @(negedge clk);
    a = ai; p = pi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ai; p = {pi[W-2:0], 1'b0};
    lat = 1;
    while (!done && lat < int'(MAXS) + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got_inv = inv;
    got_err = err;
    check_eq({tag, "_done_seen"}, W'(done), W'(1));
    check_eq({tag, "_busy_in_finish"}, W'(busy), W'(1));
    @(posedge clk); #1;
    check_eq({tag, "_done_one_cycle"}, W'(done), W'(0));
    check_eq({tag, "_busy_after"}, W'(busy), W'(0));
    check_eq({tag, "_inv_held"}, inv, got_inv);
  endtask

  initial begin
    logic [W-1:0]   gi, ei, ri, rp;
    logic           ge, ee;
    logic [2*W-1:0] prod;
    int             lat, dones;

    nrst = 1'b1; start = 1'b0; a = '0; p = '0;
    #3 nrst = 1'b0;
    #1;
    check_eq("rst_inv",  inv, '0);
    check_eq("rst_done", W'(done), W'(0));
    check_eq("rst_err",  W'(err), W'(0));
    check_eq("rst_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;

    // Small hand-checked cases
    do_req("p7a3", W'(3), W'(7), gi, ge, lat);
    check_eq("p7a3_inv", gi, W'(5));
    check_eq("p7a3_err", W'(ge), W'(0));
    check_eq("p7a3_lat", W'(lat), W'(5));

    do_req("p23a5", W'(5), W'(23), gi, ge, lat);
    check_eq("p23a5_inv", gi, W'(14));
    prod = (2*W)'(gi) * (2*W)'(5);
    check_eq("p23a5_prod", W'(prod % (2*W)'(23)), W'(1));

    // secp256k1 boundaries
    do_req("k1a1", W'(1), P256K1, gi, ge, lat);
    check_eq("k1a1_inv", gi, W'(1));
    check_eq("k1a1_err", W'(ge), W'(0));
    check_eq("k1a1_lat", W'(lat), W'(2));

    do_req("k1a2", W'(2), P256K1, gi, ge, lat);
    check_eq("k1a2_inv", gi, (P256K1 >> 1) + W'(1));
    check_eq("k1a2_err", W'(ge), W'(0));

    // Invalid operands finish immediately
    do_req("bad_a0", W'(0), W'(7), gi, ge, lat);
    check_eq("bad_a0_inv", gi, '0);
    check_eq("bad_a0_err", W'(ge), W'(1));
    check_eq("bad_a0_lat", W'(lat), W'(1));
    do_req("bad_a9", W'(9), W'(7), gi, ge, lat);
    check_eq("bad_a9_inv", gi, '0);
    check_eq("bad_a9_err", W'(ge), W'(1));
    check_eq("bad_a9_lat", W'(lat), W'(1));
    do_req("bad_p8", W'(3), W'(8), gi, ge, lat);
    check_eq("bad_p8_inv", gi, '0);
    check_eq("bad_p8_err", W'(ge), W'(1));
    check_eq("bad_p8_lat", W'(lat), W'(1));

    // Random small moduli (odd, possibly composite) against the model
    for (int i = 0; i < 24; i++) begin
      rp = W'({$urandom} & 32'h000F_FFFF) | W'(1);
      if (rp < W'(3)) rp = W'(3);
      if ($urandom_range(0, 7) == 0) ri = rp + W'($urandom_range(0, 3));
      else                           ri = W'($urandom) % rp;
      ref_inv(ri, rp, ei, ee);
      do_req($sformatf("rnd%0d", i), ri, rp, gi, ge, lat);
      check_eq($sformatf("rnd%0d_inv", i), gi, ei);
      check_eq($sformatf("rnd%0d_err", i), W'(ge), W'(ee));
    end

    // start held high with operands changing mid-flight: one done, first operands
    @(negedge clk);
    a = W'(3); p = W'(7); start = 1'b1;
    @(posedge clk); #1;
    a = W'(5); p = W'(23);
    dones = 0; gi = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        gi = inv;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("hold_dones", W'(dones), W'(1));
    check_eq("hold_inv", gi, W'(5));

    // Reset mid-inversion: outputs clear, no done for the aborted request
    @(negedge clk);
    a = W'(3); p = P256K1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check_eq("abort_inv",  inv, '0);
    check_eq("abort_done", W'(done), W'(0));
    check_eq("abort_err",  W'(err), W'(0));
    check_eq("abort_busy", W'(busy), W'(0));
    @(negedge clk) nrst = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("abort_no_done", W'(dones), W'(0));
    do_req("post_rst", W'(3), W'(7), gi, ge, lat);
    check_eq("post_rst_inv", gi, W'(5));
    check_eq("post_rst_err", W'(ge), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mod_inv_binary.md
# mod_inv_binary

Sequential modular inverter computing inv = a^-1 mod p with the binary extended Euclidean algorithm, one reduction step per clock. It sits directly upstream of the Jacobian-to-affine x conversion stage. That stage receives Z^-1 from this block and forms x = X·(Z^-1)^2 mod p with the shared modular multiplier, replacing exhaustive search with a bounded-latency inversion.

## Interface
- WIDTH, 256, operand/modulus width in bits
- MAX_STEPS, 2*WIDTH+2, iteration cap before forced error exit
- clk  input  1  clock, rising edge
- nrst  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  value to invert; requires 0 < a < p
- p  input  WIDTH  modulus; requires odd p > 1
- inv  output  WIDTH  result, registered, held until next FINISH
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = invalid operands or step cap hit
- busy  output  1  high in ITER and FINISH

## Operation
- States: IDLE, ITER, FINISH.
- IDLE + start=1, operands valid: latch p; load u=a, v=p, x1=1, x2=0, step=0; go to ITER.
- IDLE + start=1, invalid operands (a==0, a>=p, p even, p<=1): go straight to FINISH with inv=0, err=1.
- ITER, one action per cycle, evaluated in priority order:
  - if u==1: inv<=x1, err<=0, go to FINISH
  - elif v==1: inv<=x2, err<=0, go to FINISH
  - elif step==MAX_STEPS: inv<=0, err<=1, go to FINISH
  - elif u even: u<=u>>1; x1<=x1 even ? x1>>1 : (x1+p)>>1
  - elif v even: v<=v>>1; same rule on x2
  - elif u>=v: u<=u-v; x1<=x1-x2 mod p (add p on borrow)
  - else: v<=v-u; x2<=x2-x1 mod p
  - step increments on every non-exit cycle.
- FINISH: done=1 for exactly this cycle; next state IDLE.
- Width rules:
  - x1+p computed at WIDTH+1 bits before the shift.
  - Subtractions computed at WIDTH+1 bits; borrow selects the +p correction.
  - x1 and x2 always remain in [0,p).
- start while busy is ignored; there is no queueing.
- a and p are sampled only at the start edge; later changes have no effect.
- The gcd(a,p)≠1 case (p not prime) ends by the step cap with err=1.

## Timing
- Reset values: state=IDLE, inv=0, done=0, err=0, busy=0, internal registers 0.
- Start sampled at edge E0:
  - N = number of reduction cycles.
  - done is high during the cycle following edge E0+N+1.
  - Total latency N+2 cycles; worst case MAX_STEPS+2.
- Invalid operands: done high in the cycle after E0 (latency 1).
- Back-to-back operation: start may be asserted in the cycle after done; the earliest accepted start is the first IDLE cycle.
- nrst asserted mid-operation: immediate return to reset values; no done pulse for the aborted request.

## Structure
- Shared ECC package holds:
  - WIDTH default
  - secp256k1 constant P256K1 = 2^256−2^32−977
  - state encoding typedef, shared with the affine-conversion FSM
- One natural sub-module: mod_sub_p. It is a combinational (x−y) mod p at WIDTH+1 bits and is used twice, for x1 and x2. The halve-mod-p step stays inline.

## Test plan
- p=7, a=3 -> inv=5, err=0; done exactly one cycle; busy low afterwards.
- p=23, a=5 -> inv=14; check inv*a mod p == 1.
- p=P256K1, a=1 -> inv=1, latency 2 cycles. p=P256K1, a=2 -> inv=(P256K1+1)/2, err=0.
- Invalid operands -> done one cycle after start, err=1, inv=0:
  - a=0, p=7
  - a=9, p=7
  - a=3, p=8
- start=1 held continuously, plus a second start pulse during ITER with different a -> exactly one done per accepted request; the result corresponds to the first latched operands.
- nrst pulsed low 5 cycles into a P256K1 inversion -> all outputs 0, no done. A fresh request a=3, p=7 then completes with inv=5.
